// File: rtl/config_shadow_loader.sv
// Word-serial config loader: words stream into a shadow bank through a valid/ready port,
// and a single-cycle commit copies the whole shadow bank onto the active config bus at once.
module config_shadow_loader #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 27,
  parameter int ADDR_W    = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_start,
  input  logic [DATA_W-1:0]           io_d_in,
  input  logic                        io_d_valid,
  output logic                        io_d_ready,
  input  logic                        io_commit,
  input  logic [ADDR_W-1:0]           io_rd_addr,
  output logic [DATA_W-1:0]           io_rd_data,
  output logic                        io_busy,
  output logic                        io_done,
  output logic                        io_commit_done,
  output logic                        io_err,
  output logic [DATA_W*NUM_WORDS-1:0] io_configs_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL,
    S_COMMIT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_WORDS - 1);

  state_t                      r_state;
  state_t                      w_next_state;
  logic [ADDR_W-1:0]           r_ptr;
  logic [ADDR_W-1:0]           w_next_ptr;
  logic                        r_err;
  logic                        w_next_err;
  logic                        w_wr_en;
  logic                        w_last;
  logic                        r_commit_done;
  logic [DATA_W-1:0]           r_shadow [NUM_WORDS];
  logic [DATA_W*NUM_WORDS-1:0] w_shadow_flat;
  logic [DATA_W*NUM_WORDS-1:0] r_active;
  logic [DATA_W-1:0]           w_rd_word;
  logic [DATA_W-1:0]           r_rd_data;

  assign w_last = (r_ptr == LAST_PTR);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Start always wins over errors and commits, except during the commit cycle itself.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    w_next_err   = r_err;
    w_wr_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_start) begin
          w_next_state = S_LOAD;
          w_next_ptr   = '0;
          w_next_err   = 1'b0;
        end else if (io_d_valid || io_commit) begin
          w_next_err = 1'b1;
        end
      end
      S_LOAD: begin
        if (io_start) begin
          w_next_ptr = '0;
          w_next_err = 1'b0;
        end else begin
          if (io_commit) w_next_err = 1'b1;
          if (io_d_valid) begin
            w_wr_en = 1'b1;
            if (w_last) w_next_state = S_FULL;
            else        w_next_ptr   = r_ptr + 1'b1;
          end
        end
      end
      S_FULL: begin
        if (io_start) begin
          w_next_state = S_LOAD;
          w_next_ptr   = '0;
          w_next_err   = 1'b0;
        end else begin
          if (io_d_valid) w_next_err   = 1'b1;
          if (io_commit)  w_next_state = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_next_state = S_IDLE;
        if (io_d_valid) w_next_err = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_word     = '0;
    w_shadow_flat = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      w_shadow_flat[k*DATA_W +: DATA_W] = r_shadow[k];
      if (io_rd_addr == ADDR_W'(k)) w_rd_word = r_shadow[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_WORDS; k++) r_shadow[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (w_wr_en && (r_ptr == ADDR_W'(k))) r_shadow[k] <= io_d_in;
      end
    end
  end

  // Active bank only moves on the commit edge, so the tile never sees a partial load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr         <= '0;
      r_err         <= 1'b0;
      r_commit_done <= 1'b0;
      r_rd_data     <= '0;
      r_active      <= '0;
    end else begin
      r_ptr         <= w_next_ptr;
      r_err         <= w_next_err;
      r_commit_done <= (r_state == S_COMMIT);
      r_rd_data     <= w_rd_word;
      if (r_state == S_COMMIT) r_active <= w_shadow_flat;
    end
  end

  assign io_d_ready     = (r_state == S_LOAD);
  assign io_busy        = (r_state == S_LOAD) || (r_state == S_COMMIT);
  assign io_done        = (r_state == S_FULL);
  assign io_commit_done = r_commit_done;
  assign io_err         = r_err;
  assign io_rd_data     = r_rd_data;
  assign io_configs_out = r_active;

endmodule

// File: tb/tb_config_shadow_loader.sv
// Directed plus randomized bench for config_shadow_loader, checked every cycle against
// a transaction-level model of the shadow/active banks.
module tb_config_shadow_loader;

  localparam int DW = 32;
  localparam int NW = 27;
  localparam int AW = 5;
  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_FULL   = 2;
  localparam int P_COMMIT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ioStart;
  logic [DW-1:0]     ioDIn;
  logic              ioDValid;
  logic              ioDReady;
  logic              ioCommit;
  logic [AW-1:0]     ioRdAddr;
  logic [DW-1:0]     ioRdData;
  logic              ioBusy;
  logic              ioDone;
  logic              ioCommitDone;
  logic              ioErr;
  logic [DW*NW-1:0]  ioConfigsOut;

  int            mPhase;
  int            mPtr;
  logic [DW-1:0] mShadow [NW];
  logic [DW-1:0] mActive [NW];
  logic [DW-1:0] mRd;
  logic          mErr;
  logic          mCommitDone;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;
  int readyCycles = 0;

  always #5 clk = ~clk;

  config_shadow_loader #(.DATA_W(DW), .NUM_WORDS(NW), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .io_start       (ioStart),
    .io_d_in        (ioDIn),
    .io_d_valid     (ioDValid),
    .io_d_ready     (ioDReady),
    .io_commit      (ioCommit),
    .io_rd_addr     (ioRdAddr),
    .io_rd_data     (ioRdData),
    .io_busy        (ioBusy),
    .io_done        (ioDone),
    .io_commit_done (ioCommitDone),
    .io_err         (ioErr),
    .io_configs_out (ioConfigsOut)
  );

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount = checkCount + 1;
    assert (obs === exp) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBus(input string tag);
    logic [DW*NW-1:0] expBus;
    int badWord;
    badWord = -1;
    for (int k = 0; k < NW; k++) begin
      expBus[k*DW +: DW] = mActive[k];
      if (badWord < 0 && ioConfigsOut[k*DW +: DW] !== mActive[k]) badWord = k;
    end
    checkCount = checkCount + 1;
    assert (ioConfigsOut === expBus) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s: word %0d observed %0h expected %0h", tag, badWord,
             ioConfigsOut[badWord*DW +: DW], mActive[badWord]);
    end
  endtask

  // Transaction-level view of one clock edge.
  task automatic modelStep(input logic rstN, input logic st, input logic v,
                           input logic [DW-1:0] d, input logic cm, input logic [AW-1:0] addr);
    logic [DW-1:0] newRd;
    logic          newCd;
    if (!rstN) begin
      mPhase = P_IDLE;
      mPtr = 0;
      mErr = 1'b0;
      mRd = '0;
      mCommitDone = 1'b0;
      for (int k = 0; k < NW; k++) begin
        mShadow[k] = '0;
        mActive[k] = '0;
      end
    end else begin
      newRd = (int'(addr) < NW) ? mShadow[int'(addr)] : '0;
      newCd = (mPhase == P_COMMIT);
      if (mPhase == P_IDLE) begin
        if (st) begin mPhase = P_LOAD; mPtr = 0; mErr = 1'b0; end
        else if (v || cm) mErr = 1'b1;
      end else if (mPhase == P_LOAD) begin
        if (st) begin mPtr = 0; mErr = 1'b0; end
        else begin
          if (cm) mErr = 1'b1;
          if (v) begin
            mShadow[mPtr] = d;
            if (mPtr == NW - 1) mPhase = P_FULL;
            else mPtr = mPtr + 1;
          end
        end
      end else if (mPhase == P_FULL) begin
        if (st) begin mPhase = P_LOAD; mPtr = 0; mErr = 1'b0; end
        else begin
          if (v) mErr = 1'b1;
          if (cm) mPhase = P_COMMIT;
        end
      end else begin
        for (int k = 0; k < NW; k++) mActive[k] = mShadow[k];
        if (v) mErr = 1'b1;
        mPhase = P_IDLE;
      end
      mRd = newRd;
      mCommitDone = newCd;
    end
  endtask

  task automatic checkOutput();
    checkValue("ready", ioDReady, mPhase == P_LOAD);
    checkValue("busy", ioBusy, (mPhase == P_LOAD) || (mPhase == P_COMMIT));
    checkValue("done", ioDone, mPhase == P_FULL);
    checkValue("err", ioErr, mErr);
    checkValue("commit_done", ioCommitDone, mCommitDone);
    checkValue("rd_data", ioRdData, mRd);
    checkBus("configs_out");
  endtask

  task automatic applyStimulus(input logic rstN, input logic st, input logic v,
                               input logic [DW-1:0] d, input logic cm, input logic [AW-1:0] addr);
    @(negedge clk);
    reset = rstN;
    ioStart = st;
    ioDValid = v;
    ioDIn = d;
    ioCommit = cm;
    ioRdAddr = addr;
    @(posedge clk);
    if (ioDReady) readyCycles = readyCycles + 1;
    modelStep(rstN, st, v, d, cm, addr);
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic [AW-1:0] addr);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, addr);
  endtask

  task automatic loadWords(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b1, base + DW'(k), 1'b0, '0);
  endtask

  initial begin
    reset = 1'b0;
    ioStart = 1'b0;
    ioDValid = 1'b0;
    ioDIn = '0;
    ioCommit = 1'b0;
    ioRdAddr = '0;

    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    checkValue("reset_bus0", ioConfigsOut[31:0], 32'h0);
    checkValue("reset_ready", ioDReady, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    readyCycles = 0;
    loadWords(27, 32'h1000_0000);
    idle('0);
    idle('0);
    checkValue("ready_cycles", readyCycles, 27);
    checkValue("full_done", ioDone, 1'b1);
    checkValue("bus_before_commit", ioConfigsOut[31:0], 32'h0);

    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, '0);
    checkValue("no_early_pulse", ioCommitDone, 1'b0);
    idle(5'd5);
    checkValue("commit_pulse", ioCommitDone, 1'b1);
    checkValue("bus_word0", ioConfigsOut[31:0], 32'h1000_0000);
    checkValue("bus_word26", ioConfigsOut[863:832], 32'h1000_001A);
    checkValue("rd_word5", ioRdData, 32'h1000_0005);
    idle(5'd27);
    checkValue("pulse_one_cycle", ioCommitDone, 1'b0);
    checkValue("rd_out_of_range", ioRdData, 32'h0);

    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    loadWords(10, 32'h7777_0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, '0);
    loadWords(27, 32'hA5A5_0000);
    idle(5'd3);
    idle(5'd3);
    checkValue("restart_word3", ioRdData, 32'hA5A5_0003);
    checkValue("restart_err", ioErr, 1'b0);
    checkValue("restart_bus", ioConfigsOut[31:0], 32'h1000_0000);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 5'd26);
    idle(5'd26);
    checkValue("overflow_err", ioErr, 1'b1);
    checkValue("overflow_word26", ioRdData, 32'hA5A5_001A);

    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, '0);
    idle('0);
    checkValue("commit_in_load_err", ioErr, 1'b1);
    checkValue("commit_in_load_pulse", ioCommitDone, 1'b0);
    checkValue("commit_in_load_bus", ioConfigsOut[31:0], 32'h1000_0000);
    loadWords(27, 32'hB0B0_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1, '0);
    idle('0);
    checkValue("start_wins_pulse", ioCommitDone, 1'b0);
    checkValue("start_wins_ready", ioDReady, 1'b1);
    checkValue("start_wins_bus", ioConfigsOut[31:0], 32'h1000_0000);
    loadWords(27, 32'h5000_0000);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, '0);
    idle('0);
    checkValue("reload_word0", ioConfigsOut[31:0], 32'h5000_0000);
    checkValue("reload_word26", ioConfigsOut[863:832], 32'h5000_001A);

    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    loadWords(12, 32'hC000_0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC000_000C, 1'b0, 5'd3);
    checkValue("midload_ready", ioDReady, 1'b0);
    checkValue("midload_bus", ioConfigsOut[31:0], 32'h0);
    checkValue("midload_rd", ioRdData, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1, 1'b0, '0);
    checkValue("needs_start", ioDReady, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    loadWords(27, 32'hD000_0000);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    checkValue("commit_reset_bus", ioConfigsOut[863:832], 32'h0);
    checkValue("commit_reset_pulse", ioCommitDone, 1'b0);
    idle('0);
    checkValue("commit_reset_after", ioCommitDone, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 200) != 0, ($urandom % 40) == 0, ($urandom % 8) != 0,
                    $urandom, ($urandom % 6) == 0, AW'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/config_shadow_loader.md
Name: config_shadow_loader

Overview:
- Parametrised successor to the per-word config latch bank: a flop-based config memory with a word-serial valid/ready load port, an auto-incrementing write pointer, a shadow bank and an atomic commit into the active bank.
- Sits between the bitstream loader and the LUT tile, and drives the tile's flat config bus.
- The active bus never shows a partially loaded configuration.
- Adds load sequencing, completion and error status, and registered readback of the shadow bank.

Parameters:
- DATA_W, 32, width of one config word.
- NUM_WORDS, 27, number of config words (active bus width = DATA_W*NUM_WORDS).
- ADDR_W, 5, pointer/readback address width, must be >= clog2(NUM_WORDS).

Ports:
- clk  input  1  sole clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- io_start  input  1  pulse: clear pointer and error, enter LOAD.
- io_d_in  input  DATA_W  config word.
- io_d_valid  input  1  word present on io_d_in.
- io_d_ready  output  1  loader accepts a word this cycle.
- io_commit  input  1  pulse: copy shadow bank to active bank.
- io_rd_addr  input  ADDR_W  shadow readback address.
- io_rd_data  output  DATA_W  registered shadow readback.
- io_busy  output  1  state is LOAD or COMMIT.
- io_done  output  1  all NUM_WORDS words loaded (state FULL).
- io_commit_done  output  1  one-cycle pulse after the active bank updates.
- io_err  output  1  sticky protocol error.
- io_configs_out  output  DATA_W*NUM_WORDS  active config bus; word k at bits [k*DATA_W +: DATA_W].

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; ptr=0.
  - Shadow bank, active bank, io_rd_data, io_err and io_commit_done all clear to 0.
  - Reset applies mid-load and mid-commit alike; nothing partial survives.
- Handshake and outputs:
  - A word transfers on a cycle where io_d_valid & io_d_ready are both 1.
  - io_d_ready is a function of state only: 1 only in LOAD.
  - io_done = (state==FULL). io_busy = (state==LOAD | state==COMMIT).
- IDLE:
  - io_start -> LOAD, ptr=0, io_err=0.
  - io_d_valid -> word dropped, io_err=1.
  - io_commit -> ignored, io_err=1.
- LOAD:
  - A transfer writes shadow[ptr]=io_d_in and increments ptr.
  - A transfer with ptr==NUM_WORDS-1 goes to FULL; ptr stays at NUM_WORDS-1 (no wrap).
  - io_start in LOAD restarts the load: ptr=0, no write that cycle even if valid, io_err=0. Shadow contents are retained until overwritten.
  - io_commit in LOAD is ignored and sets io_err=1; the load continues.
- FULL:
  - io_commit -> COMMIT.
  - io_start -> LOAD with ptr=0.
  - If io_start and io_commit are both 1, io_start wins and no commit occurs.
  - io_d_valid in FULL is an overflow: word dropped, io_err=1.
- COMMIT (exactly one cycle):
  - The active bank is loaded from the shadow bank in one edge.
  - io_commit_done=1 on the following cycle; state returns to IDLE.
  - Inputs seen during COMMIT are ignored, except that io_d_valid sets io_err.
- Active bank:
  - Changes only on the COMMIT edge or at reset.
  - Re-committing an unchanged shadow bank (reload with identical data) is legal.
- Readback:
  - io_rd_data updates 1 cycle after io_rd_addr: shadow[io_rd_addr].
  - Any address >= NUM_WORDS returns 0.
  - Readback is valid in every state.
  - A read and a write to the same address in the same cycle return the old value.
- io_err:
  - Sticky; cleared only by io_start or reset.
  - A cycle with both io_start and an error condition leaves io_err=0, because start wins.
- Implementation constraints:
  - No latches: every storage element is a flop on clk.
  - No combinational path from io_d_valid to io_d_ready.

Test Plan:
- Reset, then io_start, then 27 back-to-back words 0x1000_0000+k with valid held high -> io_d_ready high for exactly 27 cycles; io_done=1 after the last transfer; io_configs_out stays 0.
- Then io_commit -> io_commit_done pulses 1 cycle later; io_configs_out[31:0]=0x1000_0000 and io_configs_out[863:832]=0x1000_001A; io_rd_addr=5 -> io_rd_data=0x1000_0005 next cycle; io_rd_addr=27 -> 0.
- Load 10 words, pulse io_start, then load 27 words of 0xA5A5_0000+k -> shadow word 3=0xA5A5_0003; io_err=0; active bus unchanged until commit.
- With io_done=1, assert io_d_valid with 0xDEAD_BEEF -> word dropped, io_err=1, shadow word 26 unchanged; then io_commit while in LOAD -> ignored, active bus unchanged.
- Same-cycle io_start and io_commit in FULL -> no io_commit_done, state LOAD, ptr=0, active bus unchanged.
- Drive reset low mid-load (word 12) and also during the COMMIT cycle -> all outputs 0 the next cycle and io_d_ready=0; io_start is required to resume.
